// File: rtl/lsu_stage.sv
// Load/store unit stage: takes one request at a time, runs a single memory access,
// and holds the writeback result until the consumer accepts it.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// REQ   | memory access in flight (1 cycle for stores, MEM_LAT cycles for loads)
// RESP  | result presented on out_*, held until out_ready
module lsu_stage #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_ena,
  output logic        mem_wen,
  output logic [3:0]  mem_mask,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic        req_err;
  logic [63:0] rdata_ext;

  always_comb begin
    req_illegal    = in_wen ? in_funct3[2] : (in_funct3 == 3'b111);
    req_misaligned = 1'b0;
    case (in_funct3[1:0])
      2'b01:   req_misaligned = in_addr[0];
      2'b10:   req_misaligned = |in_addr[1:0];
      2'b11:   req_misaligned = |in_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
    req_err = req_illegal | req_misaligned;
  end

  always_comb begin
    case (funct3_q)
      3'b000:  rdata_ext = {{56{mem_rdata[7]}},  mem_rdata[7:0]};
      3'b001:  rdata_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010:  rdata_ext = {{32{mem_rdata[31]}}, mem_rdata[31:0]};
      3'b100:  rdata_ext = {56'd0, mem_rdata[7:0]};
      3'b101:  rdata_ext = {48'd0, mem_rdata[15:0]};
      3'b110:  rdata_ext = {32'd0, mem_rdata[31:0]};
      default: rdata_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = wen_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    err_d    = err_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wen_d    = in_wen;
          funct3_d = in_funct3;
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          rd_d     = in_rd;
          err_d    = req_err;
          rdata_d  = '0;
          if (req_err) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = REQ;
            cnt_d   = in_wen ? 4'd1 : LAT;
          end
        end
      end
      REQ: begin
        // terminal count: this is the last access cycle, capture the load data here
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          if (!wen_q) rdata_d = rdata_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_ena   = (state_q == REQ);
    mem_wen   = mem_ena & wen_q;
    mem_mask  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_ena) begin
      case (funct3_q[1:0])
        2'b00:   mem_mask = 4'b1000;
        2'b01:   mem_mask = 4'b0100;
        2'b10:   mem_mask = 4'b0010;
        default: mem_mask = 4'b0001;
      endcase
      mem_addr = addr_q;
      if (wen_q) mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
    end
    out_valid = (state_q == RESP);
    out_rdata = out_valid ? rdata_q : '0;
    out_rd    = out_valid ? rd_q : '0;
    out_err   = out_valid & err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning the number of cycles a load holds mem_ena before mem_rdata is captured (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream request valid.
REQ-005 SHALL have port in_ready, output, 1, LSU can accept a request.
REQ-006 SHALL have port in_wen, input, 1, 1=store, 0=load.
REQ-007 SHALL have port in_funct3, input, 3, RV64 width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 SHALL have ports in_addr and in_wdata, input, 64 each, effective address and store data (data in low bits).
REQ-009 SHALL have port in_rd, input, 5, destination register tag.
REQ-010 SHALL have ports mem_ena, mem_wen, output, 1 each, memory enable and write enable.
REQ-011 SHALL have port mem_mask, output, 4, one-hot size: bit0 D, bit1 W, bit2 H, bit3 B.
REQ-012 SHALL have ports mem_addr and mem_wdata, output, 64 each, memory address and lane-positioned write data.
REQ-013 SHALL have port mem_rdata, input, 64, combinational read data, already right-shifted to bit 0, not extended.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_rdata (output, 64), out_rd (output, 5), out_err (output, 1), the writeback-side result.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP; in_ready=1 only in IDLE.
REQ-016 SHALL register in_wen, in_funct3, in_addr, in_wdata, in_rd on the edge where in_valid & in_ready, and go IDLE->REQ.
REQ-017 SHALL flag an error on accept when: funct3 illegal (load 111, store with funct3[2]=1); H with addr[0]!=0; W/WU with addr[1:0]!=0; D with addr[2:0]!=0; erroneous requests go IDLE->RESP directly with mem_ena never asserted.
REQ-018 SHALL drive mem_ena=1, mem_addr=registered addr, mem_mask from funct3[1:0] only in REQ; in IDLE/RESP mem_ena=0, mem_wen=0, mem_mask=0.
REQ-019 Stores SHALL spend exactly one cycle in REQ with mem_wen=1, mem_wdata = in_wdata << (8*addr[2:0]), so exactly one write commits per store.
REQ-020 Loads SHALL stay in REQ for MEM_LAT cycles (4-bit down-counter) with mem_wen=0, and capture mem_rdata at the end of the last REQ cycle.
REQ-021 Captured load data SHALL be sign-extended for B/H/W from bit 7/15/31, zero-extended for BU/HU/WU, passed unchanged for D.
REQ-022 Latency: request accepted at edge T -> REQ cycles T+1..T+MEM_LAT (1 for stores) -> out_valid from cycle T+MEM_LAT+1; errors: out_valid from T+1.
REQ-023 In RESP, out_valid=1 and out_rdata/out_rd/out_err SHALL hold stable until out_valid & out_ready, then go to IDLE; stores and errors report out_rdata=0.
REQ-024 out_err=1 only with out_valid for an erroneous request; out_rdata=0 in that case.
REQ-025 A new request SHALL NOT be accepted in the cycle RESP completes (no bypass); next accept is earliest one cycle later, in IDLE.
REQ-026 out_ready=0 in RESP SHALL stall indefinitely without re-issuing any memory access.

Reset
REQ-027 On rst_n=0, immediately (asynchronously): state=IDLE, counter=0, in_ready=1, mem_ena=0, mem_wen=0, mem_mask=0, mem_addr=0, mem_wdata=0, out_valid=0, out_rdata=0, out_rd=0, out_err=0.
REQ-028 Reset asserted during REQ or RESP SHALL abandon the operation: no write commits on any edge while rst_n=0, and no response is produced after release.

Verification
REQ-029 SB addr 0x8000_0005 wdata 0xAB -> one REQ cycle, mem_mask=1000, mem_wdata=0x0000_AB00_0000_0000, then out_valid, out_rdata=0, out_err=0.
REQ-030 LH addr 0x8000_0002, mem_rdata=0x0000_0000_0000_8001, MEM_LAT=1 -> out_rdata=0xFFFF_FFFF_FFFF_8001; same with LHU -> 0x0000_0000_0000_8001.
REQ-031 LW addr 0x8000_0006 -> out_valid next cycle with out_err=1, mem_ena never 1; LD addr 0x8000_0004 -> out_err=1.
REQ-032 MEM_LAT=3, LD addr 0x8000_0000 -> mem_ena high exactly 3 cycles, out_valid on 4th cycle after accept, out_rdata=mem_rdata sampled in 3rd cycle.
REQ-033 out_ready held 0 for 5 cycles in RESP -> outputs stable, in_ready=0, mem_ena=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034 rst_n pulsed low during a load's REQ -> mem_ena drops same cycle, no out_valid after release, next request served normally.
